// File: rtl/soc_timer.sv
// soc_timer: memory-mapped microsecond timer on the SOC data bus.
// A prescaler turns the system clock into a 1 us tick that advances MTIME.
// When MTIME equals MTIMECMP on a tick, MATCH is latched, which can raise irq
// and can restart MTIME from zero.
module soc_timer #(
  parameter int PERIOD_PS = 18_518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_vld,
  input  logic [31:2] bus_addr,
  input  logic [3:0]  bus_we,
  input  logic [31:0] bus_wdat,
  output logic        bus_rdy,
  output logic [31:0] bus_rdat,
  output logic        tick_1us,
  output logic        irq
);

  // Prescaler terminal count and width follow from the clock period.
  localparam int NUM_1US_CLKS  = (1_000_000 / PERIOD_PS) - 1;
  localparam int CNT_1US_WIDTH = $clog2(NUM_1US_CLKS);
  localparam logic [CNT_1US_WIDTH-1:0] PRESC_LAST = CNT_1US_WIDTH'(NUM_1US_CLKS);

  // Word offsets within the block, taken from bus_addr[3:2].
  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_MTIME    = 2'd2;
  localparam logic [1:0] REG_MTIMECMP = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_EN          = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_e;

  bus_state_e               state_q, state_d;
  logic [2:0]               ctrl_q, ctrl_d;
  logic                     match_q, match_d;
  logic [31:0]              mtime_q, mtime_d;
  logic [31:0]              mtimecmp_q, mtimecmp_d;
  logic [31:0]              rdat_q, rdat_d;
  logic [CNT_1US_WIDTH-1:0] presc_q, presc_d;
  logic                     irq_q, irq_d;

  logic        accept;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  reg_sel;
  logic        tick;
  logic        match_set;
  logic        match_clr;
  logic [31:0] mtime_ticked;
  logic        unused_addr_bits;

  // The block is selected upstream, so only the word offset is decoded.
  assign reg_sel          = bus_addr[3:2];
  assign unused_addr_bits = ^bus_addr[31:4];

  // Replace only the byte lanes whose write enable is set.
  function automatic logic [31:0] byteMerge(input logic [31:0] cur,
                                            input logic [31:0] wdat,
                                            input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = wdat[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Bus FSM: accept in IDLE, then one RESP cycle with bus_rdy high.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    bus_rdy = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_vld) begin
          accept  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        bus_rdy = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_en = accept & (|bus_we);
  assign rd_en = accept & ~(|bus_we);

  // Read data is captured from the registers as they were before this edge.
  always_comb begin
    rdat_d = '0;
    if (rd_en) begin
      case (reg_sel)
        REG_CTRL:     rdat_d = {29'd0, ctrl_q};
        REG_STATUS:   rdat_d = {31'd0, match_q};
        REG_MTIME:    rdat_d = mtime_q;
        REG_MTIMECMP: rdat_d = mtimecmp_q;
        default:      rdat_d = '0;
      endcase
    end
  end

  // Prescaler wraps at the terminal count and flags a tick in that cycle.
  always_comb begin
    presc_d = '0;
    tick    = 1'b0;
    if (ctrl_q[CTRL_EN]) begin
      if (presc_q == PRESC_LAST) begin
        tick = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Tick-driven MTIME update and compare; the all-ones wrap raises no flag.
  always_comb begin
    mtime_ticked = mtime_q;
    match_set    = 1'b0;
    if (tick) begin
      if (mtime_q == mtimecmp_q) begin
        match_set    = 1'b1;
        mtime_ticked = ctrl_q[CTRL_AUTO_RELOAD] ? 32'd0 : mtime_q + 32'd1;
      end else begin
        mtime_ticked = mtime_q + 32'd1;
      end
    end
  end

  // Bus writes override the tick update; unwritten MTIME bytes keep the pre-tick value.
  always_comb begin
    ctrl_d     = ctrl_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_ticked;
    match_clr  = 1'b0;
    if (wr_en) begin
      case (reg_sel)
        REG_CTRL: begin
          if (bus_we[0]) begin
            ctrl_d = bus_wdat[2:0];
          end
        end
        REG_STATUS:   match_clr  = bus_we[0] & bus_wdat[0];
        REG_MTIME:    mtime_d    = byteMerge(mtime_q, bus_wdat, bus_we);
        REG_MTIMECMP: mtimecmp_d = byteMerge(mtimecmp_q, bus_wdat, bus_we);
        default:      ;
      endcase
    end
    match_d = match_set | (match_q & ~match_clr);
  end

  // irq is a registered copy of MATCH gated by IRQ_EN.
  always_comb begin
    irq_d = match_q & ctrl_q[CTRL_IRQ_EN];
  end

  // Bus FSM state and captured read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      rdat_q  <= rdat_d;
    end
  end

  // Timer registers, prescaler and interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      match_q    <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '0;
      presc_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      match_q    <= match_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      irq_q      <= irq_d;
    end
  end

  assign bus_rdat = bus_rdy ? rdat_q : 32'd0;
  assign tick_1us = tick;
  assign irq      = irq_q;

endmodule

// File: tb/tb_soc_timer.sv
// tb_soc_timer: directed and randomized bench for soc_timer with a
// cycle-level reference model built from the register rules.
module tb_soc_timer;

  localparam int US_CLKS = 54;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_MTIME  = 2'd2;
  localparam logic [1:0] A_CMP    = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_vld;
  logic [31:2] bus_addr;
  logic [3:0]  bus_we;
  logic [31:0] bus_wdat;
  logic        bus_rdy;
  logic [31:0] bus_rdat;
  logic        tick_1us;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  int          tickSeen = 0;
  logic [27:0] addrHigh = '0;

  soc_timer dut (
    .clk      (clk),
    .rst      (rst),
    .bus_vld  (bus_vld),
    .bus_addr (bus_addr),
    .bus_we   (bus_we),
    .bus_wdat (bus_wdat),
    .bus_rdy  (bus_rdy),
    .bus_rdat (bus_rdat),
    .tick_1us (tick_1us),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Reference model state: register contents, clocks elapsed since enabling,
  // whether a response is due this cycle, and what it carries.
  typedef struct packed {
    logic [2:0]  ctrl;
    logic        match;
    logic [31:0] mtime;
    logic [31:0] cmp;
    logic [31:0] enCycles;
    logic        busy;
    logic [31:0] rdat;
    logic        irq;
  } model_t;

  model_t m = '0;

  function automatic logic [31:0] mergeBytes(input logic [31:0] cur, input logic [31:0] wdat,
                                             input logic [3:0] we);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wdat[8*b +: 8];
    return r;
  endfunction

  function automatic model_t modelNext(input model_t cur, input logic rstIn, input logic vld,
                                       input logic [1:0] sel, input logic [3:0] we,
                                       input logic [31:0] wdat);
    model_t n;
    logic   tickNow, hit, accept, clr;
    if (rstIn) return '0;
    n        = cur;
    tickNow  = cur.ctrl[0] && ((cur.enCycles % US_CLKS) == US_CLKS - 1);
    n.enCycles = cur.ctrl[0] ? cur.enCycles + 32'd1 : 32'd0;
    hit      = tickNow && (cur.mtime == cur.cmp);
    if (tickNow) n.mtime = (hit && cur.ctrl[2]) ? 32'd0 : cur.mtime + 32'd1;
    accept   = !cur.busy && vld;
    n.busy   = accept;
    n.rdat   = 32'd0;
    clr      = 1'b0;
    if (accept && we == 4'd0) begin
      case (sel)
        A_CTRL:   n.rdat = {29'd0, cur.ctrl};
        A_STATUS: n.rdat = {31'd0, cur.match};
        A_MTIME:  n.rdat = cur.mtime;
        default:  n.rdat = cur.cmp;
      endcase
    end
    if (accept && we != 4'd0) begin
      case (sel)
        A_CTRL:   if (we[0]) n.ctrl = wdat[2:0];
        A_STATUS: clr = we[0] && wdat[0];
        A_MTIME:  n.mtime = mergeBytes(cur.mtime, wdat, we);
        default:  n.cmp = mergeBytes(cur.cmp, wdat, we);
      endcase
    end
    n.match = hit ? 1'b1 : (clr ? 1'b0 : cur.match);
    n.irq   = cur.match && cur.ctrl[1];
    return n;
  endfunction

  // Advance the reference model on every rising edge.
  always @(posedge clk) begin
    m <= modelNext(m, rst, bus_vld, bus_addr[3:2], bus_we, bus_wdat);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [1:0] sel, input logic [3:0] we,
                               input logic [31:0] wdat);
    bus_vld  = vld;
    bus_addr = {addrHigh, sel};
    bus_we   = we;
    bus_wdat = wdat;
  endtask

  // One clock; outputs are compared against the model at the falling edge.
  task automatic stepCycle();
    logic expTick;
    @(negedge clk);
    expTick = m.ctrl[0] && ((m.enCycles % US_CLKS) == US_CLKS - 1);
    checkOutput("rdy", {31'd0, bus_rdy}, {31'd0, m.busy});
    checkOutput("rdat", bus_rdat, m.rdat);
    checkOutput("tick", {31'd0, tick_1us}, {31'd0, expTick});
    checkOutput("irq", {31'd0, irq}, {31'd0, m.irq});
    if (tick_1us) tickSeen++;
  endtask

  task automatic busAccess(input logic [1:0] sel, input logic [3:0] we, input logic [31:0] wdat,
                           output logic [31:0] rdat);
    applyStimulus(1'b1, sel, we, wdat);
    stepCycle();
    checkOutput("acc_rdy", {31'd0, bus_rdy}, 32'd1);
    rdat = bus_rdat;
    applyStimulus(1'b0, 2'd0, 4'd0, 32'd0);
    stepCycle();
  endtask

  task automatic busWrite(input logic [1:0] sel, input logic [31:0] wdat);
    logic [31:0] dummy;
    busAccess(sel, 4'hF, wdat, dummy);
  endtask

  task automatic readExpect(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    busAccess(sel, 4'd0, 32'd0, r);
    checkOutput(tag, r, exp);
  endtask

  // Run until n more ticks are seen (bounded), then one cycle so the tick edge has passed.
  task automatic waitTicks(input int n, input string tag);
    int start;
    int budget;
    start  = tickSeen;
    budget = n * US_CLKS + 60;
    for (int i = 0; i < budget && (tickSeen - start) < n; i++) stepCycle();
    checkOutput(tag, 32'(tickSeen - start), 32'(n));
    stepCycle();
  endtask

  // Issue a bus write whose accept edge coincides with a tick edge.
  task automatic writeOnTick(input logic [1:0] sel, input logic [3:0] we, input logic [31:0] wdat,
                             input string tag);
    logic        found;
    logic [31:0] dummy;
    found = 1'b0;
    for (int i = 0; i < 2 * US_CLKS && !found; i++) begin
      stepCycle();
      found = tick_1us;
    end
    checkOutput(tag, {31'd0, found}, 32'd1);
    busAccess(sel, we, wdat, dummy);
  endtask

  initial begin
    int             lastIdx;
    int             nTicks;
    logic [31:0]    seqTime [6];
    logic [31:0]    seqStat [6];
    logic [31:0]    r;
    logic [31:0]    data;
    logic [3:0]     we;
    logic [1:0]     sel;

    // Reset with a request held: nothing responds while reset is high.
    rst = 1'b1;
    applyStimulus(1'b1, A_CTRL, 4'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("rst_rdy", {31'd0, bus_rdy}, 32'd0);
      checkOutput("rst_irq", {31'd0, irq}, 32'd0);
      checkOutput("rst_tick", {31'd0, tick_1us}, 32'd0);
    end
    rst = 1'b0;
    stepCycle();
    checkOutput("rst_first_rdy", {31'd0, bus_rdy}, 32'd1);
    checkOutput("rst_first_rdat", bus_rdat, 32'd0);
    applyStimulus(1'b0, 2'd0, 4'd0, 32'd0);
    stepCycle();

    // Free-running count: 10 ticks in 540 clocks, 54 clocks apart.
    busWrite(A_CTRL, 32'd1);
    lastIdx = -1;
    nTicks  = 0;
    for (int i = 0; i < 10 * US_CLKS; i++) begin
      stepCycle();
      if (tick_1us) begin
        if (lastIdx >= 0) checkOutput("tick_gap", 32'(i - lastIdx), 32'(US_CLKS));
        lastIdx = i;
        nTicks++;
      end
    end
    checkOutput("tick_count", 32'(nTicks), 32'd10);
    readExpect(A_MTIME, 32'd10, "mtime_after_540");

    // Compare match with interrupt enabled.
    busWrite(A_CTRL, 32'd0);
    busWrite(A_MTIME, 32'd0);
    busWrite(A_CMP, 32'd5);
    busWrite(A_STATUS, 32'd1);
    busWrite(A_CTRL, 32'd3);
    waitTicks(6, "match_ticks");
    checkOutput("irq_before", {31'd0, irq}, 32'd0);
    stepCycle();
    checkOutput("irq_set", {31'd0, irq}, 32'd1);
    readExpect(A_STATUS, 32'd1, "match_status");
    readExpect(A_MTIME, 32'd6, "match_mtime");
    busWrite(A_STATUS, 32'd1);
    checkOutput("irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload sequence.
    busWrite(A_CTRL, 32'd0);
    busWrite(A_MTIME, 32'd0);
    busWrite(A_CMP, 32'd3);
    busWrite(A_STATUS, 32'd1);
    busWrite(A_CTRL, 32'd7);
    seqTime = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2};
    seqStat = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
    for (int i = 0; i < 6; i++) begin
      waitTicks(1, "reload_tick");
      readExpect(A_MTIME, seqTime[i], "reload_mtime");
      readExpect(A_STATUS, seqStat[i], "reload_status");
    end

    // All-ones wrap gives no match; byte-lane write to MTIMECMP.
    busWrite(A_CTRL, 32'd0);
    busWrite(A_CMP, 32'd9);
    busWrite(A_MTIME, 32'hFFFF_FFFF);
    busWrite(A_STATUS, 32'd1);
    busWrite(A_CTRL, 32'd1);
    waitTicks(1, "wrap_tick");
    readExpect(A_MTIME, 32'd0, "wrap_mtime");
    readExpect(A_STATUS, 32'd0, "wrap_status");
    busAccess(A_CMP, 4'b0010, 32'h0000_AB00, r);
    readExpect(A_CMP, 32'h0000_AB09, "byte_cmp");

    // Bus write to MTIME on a tick edge: bus value wins.
    busWrite(A_CTRL, 32'd0);
    busWrite(A_MTIME, 32'd0);
    busWrite(A_CTRL, 32'd1);
    writeOnTick(A_MTIME, 4'hF, 32'h0000_0100, "coll_find");
    readExpect(A_MTIME, 32'h0000_0100, "coll_mtime");

    // Partial write on a tick edge: unwritten bytes keep the pre-tick value.
    busWrite(A_CTRL, 32'd0);
    busWrite(A_MTIME, 32'h0000_01FF);
    busWrite(A_CTRL, 32'd1);
    writeOnTick(A_MTIME, 4'b0001, 32'h0000_0055, "part_find");
    readExpect(A_MTIME, 32'h0000_0155, "part_mtime");

    // W1C on the same edge as a new match: the set wins.
    busWrite(A_CTRL, 32'd0);
    busWrite(A_CMP, 32'd4);
    busWrite(A_MTIME, 32'd4);
    busWrite(A_STATUS, 32'd1);
    busWrite(A_CTRL, 32'd1);
    writeOnTick(A_STATUS, 4'b0001, 32'd1, "w1c_find");
    readExpect(A_STATUS, 32'd1, "w1c_status");
    readExpect(A_MTIME, 32'd5, "w1c_mtime");

    // Reset arriving with a request drops it.
    applyStimulus(1'b1, A_MTIME, 4'd0, 32'd0);
    rst = 1'b1;
    stepCycle();
    checkOutput("rstacc_rdy0", {31'd0, bus_rdy}, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, 4'd0, 32'd0);
    stepCycle();
    checkOutput("rstacc_rdy1", {31'd0, bus_rdy}, 32'd0);
    readExpect(A_CTRL, 32'd0, "rstacc_ctrl");
    readExpect(A_MTIME, 32'd0, "rstacc_mtime");

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 250; n++) begin
      for (int g = $urandom_range(0, 12); g > 0; g--) stepCycle();
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
      end
      addrHigh = 28'($urandom);
      sel      = 2'($urandom_range(0, 3));
      we       = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      data     = $urandom;
      if (sel == A_CTRL && $urandom_range(0, 3) != 0) data[0] = 1'b1;
      if ((sel == A_MTIME || sel == A_CMP) && $urandom_range(0, 7) != 0)
        data = 32'($urandom_range(0, 6));
      busAccess(sel, we, data, r);
    end
    addrHigh = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
